// File: rtl/stream_merger_if.sv
// Two-source / one-sink valid-ready bundle for the stream merger.
// The merger takes the slave view; sources and sink drive the master view.
interface stream_merger_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/stream_merger.sv
// Round-robin merge of two valid/ready sources into one registered output
// stage, tagging each beat with the source it came from.
module stream_merger #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    stream_merger_if.slave bus
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_src_q,   out_src_d;
    logic             last_grant_q, last_grant_d;

    logic load_en;
    logic grant_vld;
    logic grant;
    logic in0_xfer;
    logic in1_xfer;

    always_comb begin
        load_en   = !out_valid_q || bus.out_ready;
        grant_vld = bus.in0_valid || bus.in1_valid;
        if (bus.in0_valid && bus.in1_valid) begin
            grant = !last_grant_q;
        end else begin
            grant = bus.in1_valid;
        end
        // rst_n gates the readies so they drop the moment reset asserts.
        in0_xfer = rst_n && load_en && grant_vld && !grant;
        in1_xfer = rst_n && load_en && grant_vld && grant;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        if (in0_xfer || in1_xfer) begin
            out_valid_d  = 1'b1;
            out_data_d   = grant ? bus.in1_data : bus.in0_data;
            out_src_d    = grant;
            last_grant_d = grant;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.in0_ready = in0_xfer;
    assign bus.in1_ready = in1_xfer;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

    // A source that is stalled must keep presenting the same beat.
    a_in0_hold: assert property (@(posedge clk) disable iff (!rst_n)
        bus.in0_valid && !bus.in0_ready |=> bus.in0_valid && $stable(bus.in0_data));
    a_in1_hold: assert property (@(posedge clk) disable iff (!rst_n)
        bus.in1_valid && !bus.in1_ready |=> bus.in1_valid && $stable(bus.in1_data));

endmodule

// File: doc/stream_merger.md
# stream_merger

Two-input to one-output valid/ready stream merger with round-robin arbitration and a single registered output stage. It is the counterpart of the signal splitter: where the splitter fans one source out to two sinks, this block joins two sources onto one sink. It sits where two producer streams must share one consumer, delivers one beat per cycle at full rate, and tags each beat with the input it came from.

## Interface
- WIDTH, 8, data width of each input and of the output
- clk  input  1  single clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in0_valid  input  1  source 0 has a beat
- in0_data  input  WIDTH  source 0 payload
- in0_ready  output  1  source 0 beat is accepted this cycle
- in1_valid  input  1  source 1 has a beat
- in1_data  input  WIDTH  source 1 payload
- in1_ready  output  1  source 1 beat is accepted this cycle
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered payload
- out_src  output  1  source of the held beat (0 or 1)
- out_ready  input  1  sink accepts the held beat this cycle

## Operation
- One clock; reset is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_src=0, last_grant=1, so in0 wins the first contention.
- Transfer rules: an input transfer occurs when inX_valid&&inX_ready. An output transfer occurs when out_valid&&out_ready.
- load_en = !out_valid || out_ready. The output register may be refilled in the same cycle it drains.
- Grant, combinational:
  - only in0_valid: grant 0
  - only in1_valid: grant 1
  - both valid: grant !last_grant
  - neither valid: no grant
- inX_ready = load_en && grant==X. At most one ready is high per cycle.
- inX_ready may depend on both inputs' valid. No input's valid may depend on its own ready.
- On an input transfer:
  - out_data<=inX_data, out_src<=X, out_valid<=1
  - last_grant<=X, updated only on an actual transfer
- On an output transfer with no input transfer: out_valid<=0. out_data and out_src keep their last value.
- Hold: while out_valid && !out_ready, out_valid, out_data and out_src stay stable. Both readies are 0.
- Source protocol (checked by assertion): a valid held without a transfer stays asserted with unchanged data.
- Fairness: with both sources continuously valid and out_ready=1, grants alternate 0,1,0,1.
- Neither source can be starved longer than one competing beat.
- No beat is dropped, duplicated or reordered within a source.
- Arbitration is per beat. There is no packet locking.

## Timing
- Latency: one cycle from input transfer to out_valid/out_data/out_src.
- Throughput: one beat per cycle when out_ready=1.
- Back-to-back refill: out_ready=1 and an input valid in the same cycle gives an output transfer and a load in that cycle. out_valid stays 1 with the new beat.
- Backpressure: out_ready=0 while full forces both inX_ready low in the same cycle. This is a combinational path out_ready -> inX_ready.
- Reset mid-operation: asserting rst_n=0 immediately clears out_valid, and both readies fall to 0 asynchronously. Any held beat is discarded.
- First edge after reset release: readies are valid as per the grant rules.
- Simultaneous events in one cycle:
  - output drain + load: the load wins and out_valid remains 1.
  - both valid + register full and not draining: no grant and last_grant unchanged.

## Test plan
- Reset, WIDTH=8: rst_n=0 with random inputs -> out_valid=0, out_data=0x00, out_src=0, in0_ready=in1_ready=0. Release, then in0 and in1 both valid -> in0 granted first.
- Single source: in0 sends 0x11,0x22,0x33 back-to-back, in1 idle, out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, each one cycle after acceptance, out_src=0.
- Contention: in0 holds 0xA0.., in1 holds 0xB0.., both always valid, out_ready=1 for 8 cycles -> out_src 0,1,0,1,0,1,0,1. Data from each source is in order (0xA0,0xB0,0xA1,0xB1...).
- Backpressure: out holds 0x5A and out_ready=0 for 4 cycles with both sources valid -> out_data stays 0x5A, both readies are 0, last_grant unchanged. out_ready=1 -> drain and refill in the same cycle from the correct source.
- Drain without refill: out holds 0x77, out_ready=1, no input valid -> out_valid=0 next cycle. Then in1 sends 0x99 -> out_valid=1, out_data=0x99, out_src=1.
- Reset mid-stream: during the contention test, drop rst_n for one cycle while out_valid=1 -> out_valid=0 immediately. After release the first contention grants in0 and no stale beat appears.
